// File: rtl/dcache_pkg.sv
// Shared types, geometry constants and address-field helpers for the
// direct-mapped write-back data cache.
package dcache_pkg;

    localparam int LINES     = 16;
    localparam int IDX_W     = $clog2(LINES);
    localparam int LINE_BITS = 256;
    localparam int WORD_W    = 32;
    localparam int OFF_W     = 5;
    localparam int WSEL_LO   = 2;
    localparam int WSEL_HI   = 4;
    localparam int WSEL_W    = WSEL_HI - WSEL_LO + 1;
    localparam int WORDS     = LINE_BITS / WORD_W;
    localparam int TAG_W     = 32 - OFF_W - IDX_W;
    localparam int LADDR_W   = 32 - OFF_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        REFILL
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return addr[31:OFF_W+IDX_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
        return addr[OFF_W+IDX_W-1:OFF_W];
    endfunction

    function automatic logic [WSEL_W-1:0] addr_word(input logic [31:0] addr);
        return addr[WSEL_HI:WSEL_LO];
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Line store: valid/dirty bits with reset, tag and data arrays without.
// Asynchronous read port, one synchronous write (full line or single word).
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 start_i,
    input  logic [IDX_W-1:0]     rd_idx_i,
    output logic                 rd_valid_o,
    output logic                 rd_dirty_o,
    output logic [TAG_W-1:0]     rd_tag_o,
    output logic [LINE_BITS-1:0] rd_line_o,
    input  logic                 line_we_i,
    input  logic [IDX_W-1:0]     line_idx_i,
    input  logic [TAG_W-1:0]     line_tag_i,
    input  logic [LINE_BITS-1:0] line_data_i,
    input  logic                 word_we_i,
    input  logic [IDX_W-1:0]     word_idx_i,
    input  logic [WSEL_W-1:0]    word_sel_i,
    input  logic [WORD_W-1:0]    word_data_i
);

    logic [LINES-1:0]     valid_q, valid_d;
    logic [LINES-1:0]     dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [LINE_BITS-1:0] data_mem [LINES];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_mem[rd_idx_i];
    assign rd_line_o  = data_mem[rd_idx_i];

    // A refill always lands clean; a word store always dirties its line.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (line_we_i) begin
            valid_d[line_idx_i] = 1'b1;
            dirty_d[line_idx_i] = 1'b0;
        end
        if (word_we_i) begin
            dirty_d[word_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_mem[line_idx_i]  <= line_tag_i;
            data_mem[line_idx_i] <= line_data_i;
        end else if (word_we_i) begin
            data_mem[word_idx_i][{word_sel_i, 5'b0} +: WORD_W] <= word_data_i;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate D-cache controller between the
// MEM stage and a 256-bit line memory; stalls the pipeline across misses.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 start_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i
);

    state_e               state_q, state_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic [LADDR_W-1:0]   miss_line_q, miss_line_d;

    logic                 rd_valid, rd_dirty, hit;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_line;
    logic [WORD_W-1:0]    rd_words [WORDS];
    logic                 line_we, word_we;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr_i[1:0];

    dcache_sram u_sram (
        .clk_i       (clk_i),
        .start_i     (start_i),
        .rd_idx_i    (addr_idx(cpu_addr_i)),
        .rd_valid_o  (rd_valid),
        .rd_dirty_o  (rd_dirty),
        .rd_tag_o    (rd_tag),
        .rd_line_o   (rd_line),
        .line_we_i   (line_we),
        .line_idx_i  (miss_line_q[IDX_W-1:0]),
        .line_tag_i  (miss_line_q[LADDR_W-1:IDX_W]),
        .line_data_i (mem_rdata_i),
        .word_we_i   (word_we),
        .word_idx_i  (addr_idx(cpu_addr_i)),
        .word_sel_i  (addr_word(cpu_addr_i)),
        .word_data_i (cpu_wdata_i)
    );

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
        assign rd_words[gi] = rd_line[gi*WORD_W +: WORD_W];
    end

    assign hit         = rd_valid && (rd_tag == addr_tag(cpu_addr_i));
    assign line_we     = (state_q == ALLOCATE) && mem_req_q && mem_ack_i;
    assign word_we     = (state_q == IDLE) && cpu_req_i && cpu_we_i && hit;
    assign cpu_stall_o = (state_q != IDLE) || (cpu_req_i && !hit);
    assign cpu_rdata_o = ((state_q == IDLE) && cpu_req_i && !cpu_we_i && hit)
                         ? rd_words[addr_word(cpu_addr_i)] : '0;

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        miss_line_d = miss_line_q;
        case (state_q)
            IDLE: begin
                if (cpu_req_i && !hit) begin
                    miss_line_d = cpu_addr_i[31:OFF_W];
                    mem_req_d   = 1'b1;
                    if (rd_valid && rd_dirty) begin
                        state_d     = WRITEBACK;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {rd_tag, addr_idx(cpu_addr_i), 5'b0};
                        mem_wdata_d = rd_line;
                    end else begin
                        state_d    = ALLOCATE;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {cpu_addr_i[31:OFF_W], 5'b0};
                    end
                end
            end
            WRITEBACK: begin
                // Drop the request for one cycle so each transfer is a distinct handshake.
                if (mem_ack_i) begin
                    state_d    = ALLOCATE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {miss_line_q, 5'b0};
                end
            end
            ALLOCATE: begin
                if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end else if (mem_ack_i) begin
                    state_d   = REFILL;
                    mem_req_d = 1'b0;
                end
            end
            REFILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            miss_line_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            miss_line_q <= miss_line_d;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: word-level golden memory plus a per-index
// residency model predicting stall length, write-backs and load data.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         start_i = 1'b0;
    logic         cpu_req_i = 1'b0;
    logic         cpu_we_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_wdata_i = '0;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i = '0;
    logic         mem_ack_i;
    logic         ack_resp = 1'b0;
    logic         ack_man = 1'b0;

    assign mem_ack_i = ack_resp | ack_man;

    dcache_controller dut (
        .clk_i       (clk_i),
        .start_i     (start_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit           we;
        logic [31:0]  addr;
        logic [255:0] data;
    } mreq_t;

    int           errors = 0;
    int           checks = 0;
    mreq_t        exp_q[$];
    logic [31:0]  dram [logic [31:0]];
    logic [31:0]  gmem [logic [31:0]];
    bit           mvalid [16];
    bit           mdirty [16];
    logic [22:0]  mtag   [16];
    int           lat_wb = 1;
    int           lat_al = 1;
    bit           auto_ack = 1'b1;
    int           wb_count = 0;
    int           fetch_count = 0;
    logic [31:0]  last_wb_addr = '0;
    logic [31:0]  last_fetch_addr = '0;
    logic [255:0] last_wb_data = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] dword(input logic [31:0] a);
        return dram.exists(a) ? dram[a] : init_word(a);
    endfunction

    function automatic logic [31:0] gword(input logic [31:0] a);
        return gmem.exists(a) ? gmem[a] : dword(a);
    endfunction

    function automatic logic [255:0] dram_line(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = dword(la + 32'(k * 4));
        return l;
    endfunction

    function automatic logic [255:0] golden_line(input logic [31:0] la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = gword(la + 32'(k * 4));
        return l;
    endfunction

    // Memory side: checks each request against the queued prediction, then acks after the chosen latency.
    initial begin
        logic [31:0]  a0;
        logic [255:0] d0;
        bit           w0;
        int           lat;
        mreq_t        e;
        forever begin
            @(posedge clk_i); #1;
            if (auto_ack && start_i && mem_req_o) begin
                a0 = mem_addr_o;
                w0 = mem_we_o;
                d0 = mem_wdata_o;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got req we=%0d addr=%0h expected no request", w0, a0);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_we", 256'(w0), 256'(e.we));
                    chk("req_addr", 256'(a0), 256'(e.addr));
                    if (e.we) chk("wb_data", d0, e.data);
                end
                lat = w0 ? lat_wb : lat_al;
                for (int k = 1; k < lat; k++) begin
                    @(posedge clk_i); #1;
                    chk("req_hold", {mem_req_o, mem_we_o, mem_addr_o}, {1'b1, w0, a0});
                end
                if (!w0) mem_rdata_i = dram_line(a0);
                ack_resp = 1'b1;
                @(posedge clk_i);
                if (w0) begin
                    for (int k = 0; k < 8; k++) dram[a0 + 32'(k * 4)] = d0[k*32 +: 32];
                    wb_count++;
                    last_wb_addr = a0;
                    last_wb_data = d0;
                end else begin
                    fetch_count++;
                    last_fetch_addr = a0;
                end
                #1;
                ack_resp = 1'b0;
                mem_rdata_i = '0;
                chk("req_drop", 256'(mem_req_o), 256'(0));
            end
        end
    end

    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input int lwb, input int lal, output int ncyc, output logic [31:0] rd);
        logic [3:0]  idx;
        logic [22:0] tg;
        bit          hit;
        int          exp_st;
        mreq_t       e;
        idx = addr[8:5];
        tg  = addr[31:9];
        hit = mvalid[idx] && (mtag[idx] == tg);
        exp_st = 0;
        if (!hit) begin
            if (mvalid[idx] && mdirty[idx]) begin
                exp_st = 3 + lal + lwb;
                e.we   = 1'b1;
                e.addr = {mtag[idx], idx, 5'b0};
                e.data = golden_line(e.addr);
                exp_q.push_back(e);
            end else begin
                exp_st = 2 + lal;
            end
            e.we   = 1'b0;
            e.addr = {addr[31:5], 5'b0};
            e.data = '0;
            exp_q.push_back(e);
        end
        lat_wb = lwb;
        lat_al = lal;
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wd;
        ncyc = 0;
        rd   = '0;
        forever begin
            @(negedge clk_i);
            chk("stall", 256'(cpu_stall_o), 256'(ncyc < exp_st));
            if (!cpu_stall_o) begin
                rd = cpu_rdata_o;
                if (!we) chk("load_data", 256'(cpu_rdata_o), 256'(gword(addr)));
                if (hit) chk("hit_no_req", 256'(mem_req_o), 256'(0));
                break;
            end
            ncyc++;
            if (ncyc > 100) begin
                checks++;
                errors++;
                $display("FAIL stall_timeout: got stall still high after %0d cycles expected %0d", ncyc, exp_st);
                break;
            end
        end
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0;
        $display("access we=%0d addr=%08h wdata=%08h stall=%0d rdata=%08h", we, addr, wd, ncyc, rd);
        if (we) gmem[{addr[31:2], 2'b00}] = wd;
        mdirty[idx] = (hit ? mdirty[idx] : 1'b0) | we;
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

    initial begin
        int          n;
        int          cnt_before;
        logic [31:0] rd;
        logic [31:0] ra;

        for (int k = 0; k < 8; k++) dram[32'h40 + 32'(k * 4)] = 32'h1000_0000 + 32'(k);

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_stall", 256'(cpu_stall_o), 256'(0));
        chk("rst_req", 256'(mem_req_o), 256'(0));
        chk("rst_we", 256'(mem_we_o), 256'(0));
        chk("rst_addr", 256'(mem_addr_o), 256'(0));
        chk("rst_wdata", mem_wdata_o, 256'(0));
        chk("rst_rdata", 256'(cpu_rdata_o), 256'(0));
        @(posedge clk_i); #1;
        start_i = 1'b1;
        @(posedge clk_i); #1;

        // 1: cold load miss, latency 3
        access(1'b0, 32'h40, 32'h0, 1, 3, n, rd);
        chk("t1_stall_cycles", 256'(n), 256'(5));
        chk("t1_fetch_addr", 256'(last_fetch_addr), 256'(32'h40));
        chk("t1_rdata", 256'(rd), 256'(32'h1000_0000));

        // 2: hit on the same line
        cnt_before = fetch_count;
        access(1'b0, 32'h44, 32'h0, 1, 1, n, rd);
        chk("t2_stall_cycles", 256'(n), 256'(0));
        chk("t2_rdata", 256'(rd), 256'(32'h1000_0001));
        chk("t2_no_fetch", 256'(fetch_count), 256'(cnt_before));

        // 3: store hit then conflicting load forces write-back
        access(1'b1, 32'h40, 32'hDEAD_BEEF, 1, 1, n, rd);
        chk("t3_store_stall", 256'(n), 256'(0));
        access(1'b0, 32'h240, 32'h0, 2, 2, n, rd);
        chk("t3_stall_cycles", 256'(n), 256'(7));
        chk("t3_wb_addr", 256'(last_wb_addr), 256'(32'h40));
        chk("t3_wb_word0", 256'(last_wb_data[31:0]), 256'(32'hDEAD_BEEF));
        chk("t3_wb_word1", 256'(last_wb_data[63:32]), 256'(32'h1000_0001));
        chk("t3_fetch_addr", 256'(last_fetch_addr), 256'(32'h240));

        // 4: store miss to a clean line, then evict it
        cnt_before = wb_count;
        access(1'b1, 32'h80, 32'h1234_5678, 1, 1, n, rd);
        chk("t4_store_stall", 256'(n), 256'(3));
        chk("t4_no_wb", 256'(wb_count), 256'(cnt_before));
        access(1'b0, 32'h280, 32'h0, 1, 1, n, rd);
        chk("t4_evict_stall", 256'(n), 256'(5));
        chk("t4_wb_addr", 256'(last_wb_addr), 256'(32'h80));
        chk("t4_wb_word0", 256'(last_wb_data[31:0]), 256'(32'h1234_5678));

        // 5: reset in the middle of ALLOCATE, acks during and after reset
        auto_ack = 1'b0;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40;
        @(posedge clk_i); #1;
        chk("t5_alloc_req", 256'(mem_req_o), 256'(1));
        chk("t5_alloc_we", 256'(mem_we_o), 256'(0));
        chk("t5_alloc_addr", 256'(mem_addr_o), 256'(32'h40));
        start_i = 1'b0;
        cpu_req_i = 1'b0;
        #1;
        chk("t5_rst_req", 256'(mem_req_o), 256'(0));
        chk("t5_rst_addr", 256'(mem_addr_o), 256'(0));
        chk("t5_rst_stall", 256'(cpu_stall_o), 256'(0));
        @(negedge clk_i);
        ack_man = 1'b1;
        @(posedge clk_i); #1;
        ack_man = 1'b0;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        ack_man = 1'b1;
        @(posedge clk_i); #1;
        ack_man = 1'b0;
        chk("t5_late_ack_req", 256'(mem_req_o), 256'(0));
        chk("t5_late_ack_stall", 256'(cpu_stall_o), 256'(0));
        for (int k = 0; k < 16; k++) begin
            mvalid[k] = 1'b0;
            mdirty[k] = 1'b0;
        end
        gmem.delete();
        auto_ack = 1'b1;
        access(1'b0, 32'h40, 32'h0, 1, 2, n, rd);
        chk("t5_miss_stall", 256'(n), 256'(4));
        chk("t5_rdata", 256'(rd), 256'(32'hDEAD_BEEF));

        // 6: stray ack while idle
        ack_man = 1'b1;
        @(posedge clk_i); #1;
        ack_man = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("t6_stall", 256'(cpu_stall_o), 256'(0));
            chk("t6_req", {mem_req_o, mem_we_o}, 256'(0));
            chk("t6_addr", 256'(mem_addr_o), 256'(32'h40));
        end
        @(posedge clk_i); #1;
        access(1'b0, 32'h40, 32'h0, 1, 1, n, rd);
        chk("t6_hit_stall", 256'(n), 256'(0));
        chk("t6_rdata", 256'(rd), 256'(32'hDEAD_BEEF));

        // Random traffic over a small set of aliasing tags
        for (int t = 0; t < 300; t++) begin
            ra = {21'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  3'($urandom_range(0, 7)), 2'b00};
            access(1'($urandom_range(0, 1)), ra, $urandom, $urandom_range(1, 4),
                   $urandom_range(1, 4), n, rd);
        end

        chk("exp_queue_empty", 256'(exp_q.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
